// File: rtl/crypt_line_buffer_if.sv
// Cache-line request/response bundle plus the single-word main-memory port (lxb2mm/mm2lxb).
// The slave modport is the line buffer's view; master is the cache/memory side that drives it.
interface crypt_line_buffer_if #(
    parameter int ADDRESS_BITS = 12,
    parameter int OFFSET_BITS  = 3
);
    localparam int WORDS = 1 << OFFSET_BITS;

    logic [31:0]             key;
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic                    req_plain;
    logic [ADDRESS_BITS-1:0] req_address;
    logic [32*WORDS-1:0]     req_data;
    logic                    resp_valid;
    logic [32*WORDS-1:0]     resp_data;

    logic [2:0]              lxb2mm_msg;
    logic [ADDRESS_BITS:0]   lxb2mm_address;
    logic [31:0]             lxb2mm_data;
    logic [2:0]              mm2lxb_msg;
    logic [ADDRESS_BITS:0]   mm2lxb_address;
    logic [31:0]             mm2lxb_data;

    modport slave (
        input  key, req_valid, req_write, req_plain, req_address, req_data,
        output req_ready, resp_valid, resp_data,
        output lxb2mm_msg, lxb2mm_address, lxb2mm_data,
        input  mm2lxb_msg, mm2lxb_address, mm2lxb_data
    );

    modport master (
        output key, req_valid, req_write, req_plain, req_address, req_data,
        input  req_ready, resp_valid, resp_data,
        input  lxb2mm_msg, lxb2mm_address, lxb2mm_data,
        output mm2lxb_msg, mm2lxb_address, mm2lxb_data
    );
endinterface

// File: rtl/crypt_line_buffer.sv
// Serialises a cache-line fill/writeback into single-word memory transactions, XOR-ciphering
// encrypted-region words with an address-tweaked key; one line in flight, req_ready only in IDLE.
module crypt_line_buffer #(
    parameter int ADDRESS_BITS = 12,
    parameter int OFFSET_BITS  = 3
) (
    input logic                clock,
    input logic                reset,
    crypt_line_buffer_if.slave bus
);
    localparam int WORDS     = 1 << OFFSET_BITS;
    localparam int LINE_BITS = 32 * WORDS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] MSG_NO_REQ = 3'd0;
    localparam logic [2:0] MSG_R_REQ  = 3'd1;
    localparam logic [2:0] MSG_WB_REQ = 3'd2;
    localparam logic [2:0] MEM_READY  = 3'd3;
    localparam logic [2:0] MEM_SENT   = 3'd4;

    localparam logic [ADDRESS_BITS-1:0] OFFSET_MASK = ADDRESS_BITS'(WORDS - 1);
    localparam logic [OFFSET_BITS-1:0]  LAST_WORD   = OFFSET_BITS'(WORDS - 1);

    function automatic logic [31:0] keystream(input logic [31:0] k,
                                              input logic [ADDRESS_BITS-1:0] a);
        logic [31:0] x;
        logic [4:0]  rot;
        x   = k ^ 32'(a);
        rot = a[4:0];
        // right shift by (32-rot) mod 32 folds rot==0 into the same expression
        return (x << rot) | (x >> (5'd0 - rot));
    endfunction

    logic [1:0]              state_q,     state_d;
    logic [OFFSET_BITS-1:0]  wc_q,        wc_d;
    logic [31:0]             key_q,       key_d;
    logic [ADDRESS_BITS-1:0] base_q,      base_d;
    logic                    write_q,     write_d;
    logic                    plain_q,     plain_d;
    logic [LINE_BITS-1:0]    line_q,      line_d;
    logic [LINE_BITS-1:0]    resp_data_q, resp_data_d;
    logic [2:0]              msg_q,       msg_d;
    logic [ADDRESS_BITS:0]   addr_q,      addr_d;
    logic [31:0]             wdata_q,     wdata_d;

    logic [ADDRESS_BITS-1:0] word_addr;
    logic [31:0]             ks;
    logic [31:0]             line_word;
    logic [31:0]             enc_word;
    logic [31:0]             dec_word;
    logic [2:0]              expect_msg;
    logic                    resp_hit;

    always_comb begin
        word_addr  = base_q | ADDRESS_BITS'(wc_q);
        ks         = keystream(key_q, word_addr);
        line_word  = line_q[32*wc_q +: 32];
        enc_word   = plain_q ? line_word : (line_word ^ ks);
        dec_word   = plain_q ? bus.mm2lxb_data : (bus.mm2lxb_data ^ ks);
        expect_msg = write_q ? MEM_SENT : MEM_READY;
        // addr_q is the address actually on the bus, so responses are matched against it
        resp_hit   = (bus.mm2lxb_msg == expect_msg) && (bus.mm2lxb_address == addr_q);
    end

    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        key_d       = key_q;
        base_d      = base_q;
        write_d     = write_q;
        plain_d     = plain_q;
        line_d      = line_q;
        resp_data_d = resp_data_q;
        msg_d       = msg_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    key_d   = bus.key;
                    base_d  = bus.req_address & ~OFFSET_MASK;
                    write_d = bus.req_write;
                    plain_d = bus.req_plain;
                    line_d  = bus.req_data;
                    wc_d    = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                msg_d   = write_q ? MSG_WB_REQ : MSG_R_REQ;
                addr_d  = {plain_q, word_addr};
                wdata_d = enc_word;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (resp_hit) begin
                    if (!write_q) begin
                        resp_data_d[32*wc_q +: 32] = dec_word;
                    end
                    if (wc_q == LAST_WORD) begin
                        msg_d   = MSG_NO_REQ;
                        state_d = S_DONE;
                    end else begin
                        wc_d    = wc_q + OFFSET_BITS'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                msg_d   = MSG_NO_REQ;
                state_d = S_IDLE;
            end
            default: begin
                msg_d   = MSG_NO_REQ;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wc_q        <= '0;
            key_q       <= '0;
            base_q      <= '0;
            write_q     <= 1'b0;
            plain_q     <= 1'b0;
            line_q      <= '0;
            resp_data_q <= '0;
            msg_q       <= MSG_NO_REQ;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            wc_q        <= wc_d;
            key_q       <= key_d;
            base_q      <= base_d;
            write_q     <= write_d;
            plain_q     <= plain_d;
            line_q      <= line_d;
            resp_data_q <= resp_data_d;
            msg_q       <= msg_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.req_ready      = (state_q == S_IDLE);
    assign bus.resp_valid     = (state_q == S_DONE);
    assign bus.resp_data      = resp_data_q;
    assign bus.lxb2mm_msg     = msg_q;
    assign bus.lxb2mm_address = addr_q;
    assign bus.lxb2mm_data    = wdata_q;
endmodule

// File: tb/tb_crypt_line_buffer.sv
// Randomised line fills/writebacks against a word-addressed memory model and an arithmetic
// reference of the keystream cipher; covers latency, stray responses, back-to-back and reset.
module tb_crypt_line_buffer;
    localparam int AB = 12;
    localparam int OB = 3;
    localparam int W  = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    crypt_line_buffer_if #(.ADDRESS_BITS(AB), .OFFSET_BITS(OB)) bus ();

    crypt_line_buffer #(.ADDRESS_BITS(AB), .OFFSET_BITS(OB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_ks(input logic [31:0] k, input int a);
        logic [31:0] x;
        logic [63:0] t;
        int          r;
        x = k ^ 32'(a);
        r = a % 32;
        t = {32'b0, x} << r;
        return t[31:0] | t[63:32];
    endfunction

    // memory model: answers each new request after mem_lat cycles of visibility
    logic [31:0] mem [0:8191];
    int          mem_lat   = 1;
    bit          mem_stray = 1'b0;
    logic [15:0] req_log [$];
    logic [255:0] exp_resp = '0;

    bit          cur_vld  = 1'b0;
    bit          cur_done = 1'b0;
    logic [2:0]  cur_msg;
    logic [12:0] cur_addr;
    logic [31:0] cur_data;
    int          age;

    initial begin
        bus.mm2lxb_msg     = 3'd0;
        bus.mm2lxb_address = '0;
        bus.mm2lxb_data    = '0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                cur_vld = 1'b0;
            end else if (bus.lxb2mm_msg != 3'd0) begin
                if (!cur_vld || bus.lxb2mm_msg != cur_msg || bus.lxb2mm_address != cur_addr) begin
                    if (cur_vld) check_eq("req_changed_before_resp", cur_done, 1);
                    cur_vld  = 1'b1;
                    cur_done = 1'b0;
                    cur_msg  = bus.lxb2mm_msg;
                    cur_addr = bus.lxb2mm_address;
                    cur_data = bus.lxb2mm_data;
                    age      = 1;
                    req_log.push_back({cur_msg, cur_addr});
                end else begin
                    age++;
                    if (!cur_done) check_eq("wdata_stable", bus.lxb2mm_data, cur_data);
                end
            end else begin
                if (cur_vld) check_eq("req_dropped_before_resp", cur_done, 1);
                cur_vld = 1'b0;
            end

            bus.mm2lxb_msg     = 3'd0;
            bus.mm2lxb_address = '0;
            bus.mm2lxb_data    = '0;
            if (!reset && cur_vld && !cur_done) begin
                if (age == mem_lat) begin
                    bus.mm2lxb_address = cur_addr;
                    if (cur_msg == 3'd1) begin
                        bus.mm2lxb_msg  = 3'd3;
                        bus.mm2lxb_data = mem[cur_addr];
                    end else begin
                        mem[cur_addr]  = cur_data;
                        bus.mm2lxb_msg = 3'd4;
                    end
                    cur_done = 1'b1;
                end else if (mem_stray && age == 1) begin
                    bus.mm2lxb_msg     = (cur_msg == 3'd1) ? 3'd3 : 3'd4;
                    bus.mm2lxb_address = cur_addr ^ 13'h001;
                    bus.mm2lxb_data    = $urandom;
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_req_ready"},  bus.req_ready, 1);
        check_eq({tag, "_resp_valid"}, bus.resp_valid, 0);
        check_eq({tag, "_msg"},        bus.lxb2mm_msg, 0);
        check_eq({tag, "_addr"},       bus.lxb2mm_address, 0);
        check_eq({tag, "_data"},       bus.lxb2mm_data, 0);
        for (int kk = 0; kk < W; kk++)
            check_eq({tag, "_resp_data"}, bus.resp_data[32*kk +: 32], 0);
    endtask

    task automatic line_op(input bit wr, input bit pl, input logic [11:0] a,
                           input logic [31:0] k, input logic [255:0] line,
                           input int n, input bit stray, input bit hold, output int waited);
        int          lat;
        int          base;
        logic [12:0] ma;
        logic [31:0] w;
        mem_lat   = n;
        mem_stray = stray;
        req_log.delete();
        @(negedge clock);
        bus.key         = k;
        bus.req_write   = wr;
        bus.req_plain   = pl;
        bus.req_address = a;
        bus.req_data    = line;
        bus.req_valid   = 1'b1;
        waited = 0;
        while (!bus.req_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check_eq("req_ready_idle", bus.req_ready, 1);
        @(posedge clock);
        #1;
        if (!hold) begin
            bus.req_valid = 1'b0;
            bus.key       = $urandom;
        end
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            if (!hold) bus.key = $urandom;
            if (bus.resp_valid) begin
                lat = c;
                break;
            end
            check_eq("req_ready_busy", bus.req_ready, 0);
        end
        check_eq("latency", lat, 8 * (1 + n) + 1);
        check_eq("req_count", req_log.size(), W);
        base = int'(a) & ~(W - 1);
        for (int kk = 0; kk < W; kk++) begin
            ma = {pl, 12'(base + kk)};
            if (kk < req_log.size())
                check_eq("req_addr", req_log[kk], {(wr ? 3'd2 : 3'd1), ma});
            if (wr) begin
                w = line[32*kk +: 32];
                check_eq("wb_data", mem[ma], pl ? w : (w ^ ref_ks(k, base + kk)));
            end else begin
                exp_resp[32*kk +: 32] = pl ? mem[ma] : (mem[ma] ^ ref_ks(k, base + kk));
            end
        end
        for (int kk = 0; kk < W; kk++)
            check_eq("resp_word", bus.resp_data[32*kk +: 32], exp_resp[32*kk +: 32]);
        if (!hold) begin
            @(negedge clock);
            check_eq("resp_pulse", bus.resp_valid, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [255:0] line;
        logic [31:0]  p [0:7];
        int           waited;
        int           n;

        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        bus.key = '0; bus.req_valid = 0; bus.req_write = 0; bus.req_plain = 0;
        bus.req_address = '0; bus.req_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;

        // encrypted fill, explicit plaintext recovery
        for (int kk = 0; kk < W; kk++) begin
            p[kk] = $urandom;
            mem[13'h0010 + kk] = p[kk] ^ ref_ks(32'hA5A5_0000, 32'h010 + kk);
        end
        line_op(0, 0, 12'h013, 32'hA5A5_0000, '0, 1, 0, 0, waited);
        for (int kk = 0; kk < W; kk++) check_eq("enc_fill_plain", bus.resp_data[32*kk +: 32], p[kk]);

        // plaintext fill returns memory contents untouched
        line_op(0, 1, 12'h020, $urandom, '0, 2, 0, 0, waited);
        for (int kk = 0; kk < W; kk++)
            check_eq("plain_fill", bus.resp_data[32*kk +: 32], mem[13'h1020 + kk]);

        // encrypted writeback of 0..7, then read it back
        for (int kk = 0; kk < W; kk++) line[32*kk +: 32] = 32'(kk);
        line_op(1, 0, 12'h008, 32'h1234_5678, line, 1, 0, 0, waited);
        line_op(0, 0, 12'h00C, 32'h1234_5678, '0, 2, 0, 0, waited);
        for (int kk = 0; kk < W; kk++) check_eq("wb_readback", bus.resp_data[32*kk +: 32], kk);

        // slow memory with a stray wrong-address response
        line_op(0, 0, 12'h1F7, $urandom, '0, 3, 1, 0, waited);

        // back-to-back with req_valid held
        line_op(0, 0, 12'h300, 32'hDEAD_BEEF, '0, 1, 0, 1, waited);
        line_op(0, 0, 12'h300, 32'hDEAD_BEEF, '0, 1, 0, 0, waited);
        check_eq("b2b_accept_wait", waited, 0);

        // reset during WAIT of word 4
        mem_lat = 3; mem_stray = 0;
        req_log.delete();
        @(negedge clock);
        bus.key = 32'h0BAD_F00D; bus.req_write = 0; bus.req_plain = 0;
        bus.req_address = 12'h040; bus.req_valid = 1;
        @(posedge clock);
        #1 bus.req_valid = 0;
        for (int c = 0; c < 200 && req_log.size() < 5; c++) @(negedge clock);
        check_eq("rst_reached_w4", req_log.size(), 5);
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        exp_resp = '0;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check_eq("midrst_no_resp", bus.resp_valid, 0);
        end
        line_op(0, 0, 12'h040, 32'h0BAD_F00D, '0, 1, 0, 0, waited);

        // randomised traffic
        for (int t = 0; t < 24; t++) begin
            for (int kk = 0; kk < W; kk++) line[32*kk +: 32] = $urandom;
            n = 1 + int'($urandom_range(0, 2));
            line_op(1'($urandom), 1'($urandom), 12'($urandom), $urandom, line, n,
                    1'($urandom), 0, waited);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
